// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: program-execution controller sitting between the instruction
// ROM and the control decoder. It owns the program counter, the Start/Ack run
// handshake and the executed-cycle counter. At Start it jumps to the base
// address of the selected program slot. While running it supports absolute
// jumps and signed relative branches, and it stops on the all-ones halt word.
//
// Optional feature: define PROG_RUN_CTRL_WATCHDOG_EN to end a run when the
// cycle counter reaches MAXCYC. Such a run reports Timeout=1. Without the
// macro, Timeout is tied low, runs are unbounded and CycleCt saturates.
//
// Ports:
//   Clk          in   1            clock, rising edge
//   Reset        in   1            synchronous, active-high reset
//   Start        in   1            run request (ignored while running)
//   ProgSel      in   log2(NPROG)  program slot, taken with an accepted Start
//   Instruction  in   IW           ROM word at ProgCtr; all ones = halt
//   BranchAbs    in   1            absolute jump to Target
//   BranchRelEn  in   1            relative branch, taken when ALU_flag=1
//   ALU_flag     in   1            ALU zero flag
//   Target       in   PW           jump address or signed branch offset
//   ProgCtr      out  PW           program counter (registered)
//   Busy         out  1            run in progress
//   Ack          out  1            run finished
//   CycleCt      out  CW           executed-cycle count of current/last run
//   Timeout      out  1            last run was ended by the watchdog
module prog_run_ctrl #(
    parameter int          PW          = 10,
    parameter int          IW          = 9,
    parameter int          CW          = 16,
    parameter int          NPROG       = 4,
    parameter int          PROG_STRIDE = 256,
    parameter int unsigned MAXCYC      = 32'h0000_FFF0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [$clog2(NPROG)-1:0] ProgSel,
    input  logic [IW-1:0]            Instruction,
    input  logic                     BranchAbs,
    input  logic                     BranchRelEn,
    input  logic                     ALU_flag,
    input  logic [PW-1:0]            Target,
    output logic [PW-1:0]            ProgCtr,
    output logic                     Busy,
    output logic                     Ack,
    output logic [CW-1:0]            CycleCt,
    output logic                     Timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [PW-1:0]         pc;
    logic [CW-1:0]         cyc;
    logic                  is_halt;
    logic [CW-1:0]         cyc_inc;
    logic [31:0]           start_full;
    logic [PW-1:0]         start_pc;
    logic signed [PW-1:0]  rel_off;
    logic [PW-1:0]         pc_next;

    assign is_halt = (Instruction == {IW{1'b1}});

    // Cycle counter sticks at all ones instead of wrapping.
    assign cyc_inc = (cyc == {CW{1'b1}}) ? cyc : cyc + CW'(1);

    // Slot base address, truncated to the program-counter width.
    assign start_full = 32'(ProgSel) * 32'(PROG_STRIDE);
    assign start_pc   = start_full[PW-1:0];

    // Two's-complement offset: a plain PW-bit add modulo 2^PW gives the
    // signed result, so the sum needs no sign extension.
    assign rel_off = signed'(Target);

    always_comb begin
        pc_next = pc + PW'(1);
        if (BranchAbs) begin
            pc_next = Target;
        end else if (BranchRelEn && ALU_flag) begin
            pc_next = pc + unsigned'(rel_off);
        end
    end

`ifdef PROG_RUN_CTRL_WATCHDOG_EN
    logic timeout_r;
    logic limit_hit;

    assign limit_hit = (cyc_inc == CW'(MAXCYC));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            pc        <= '0;
            cyc       <= '0;
            timeout_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state     <= RUN;
                        pc        <= start_pc;
                        cyc       <= '0;
                        timeout_r <= 1'b0;
                    end
                end
                RUN: begin
                    // Halt takes precedence over the watchdog limit.
                    if (is_halt) begin
                        state <= DONE;
                    end else begin
                        cyc <= cyc_inc;
                        if (limit_hit) begin
                            state     <= DONE;
                            timeout_r <= 1'b1;
                        end else begin
                            pc <= pc_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Timeout = timeout_r;
`else
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= '0;
            cyc   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state <= RUN;
                        pc    <= start_pc;
                        cyc   <= '0;
                    end
                end
                RUN: begin
                    // The halt word freezes the PC on its own address.
                    if (is_halt) begin
                        state <= DONE;
                    end else begin
                        cyc <= cyc_inc;
                        pc  <= pc_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Timeout = 1'b0;
`endif

    assign ProgCtr = pc;
    assign CycleCt = cyc;
    assign Busy    = (state == RUN);
    assign Ack     = (state == DONE);

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Testbench for prog_run_ctrl. It has three parts:
//   - a directed vector table of per-cycle inputs and expected outputs;
//   - hand-written multi-cycle sequences on a second instance, which check
//     counter saturation (or the watchdog when PROG_RUN_CTRL_WATCHDOG_EN is
//     defined);
//   - randomized traffic checked against an arithmetic reference model.
module tb_prog_run_ctrl;

    localparam int PW = 10;
    localparam int IW = 9;
    localparam int CW = 16;
    localparam int NPROG = 4;
`ifdef PROG_RUN_CTRL_WATCHDOG_EN
    localparam int          CW2   = 16;
    localparam int unsigned MAX2  = 8;
`else
    localparam int          CW2   = 4;
    localparam int unsigned MAX2  = 32'h0000_FFF0;
`endif
    localparam logic [8:0] NOP  = 9'h000;
    localparam logic [8:0] HALT = 9'h1FF;

    logic            clk = 1'b0;
    logic            rst, start, babs, brel, flag;
    logic [1:0]      sel;
    logic [8:0]      instr;
    logic [9:0]      target;
    logic [9:0]      pc, pc2;
    logic            busy, ack, to, busy2, ack2, to2;
    logic [CW-1:0]   cyc;
    logic [CW2-1:0]  cyc2;

    always #5 clk = ~clk;

    prog_run_ctrl #(.PW(PW), .IW(IW), .CW(CW), .NPROG(NPROG), .PROG_STRIDE(256),
                    .MAXCYC(32'h0000_FFF0)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .ProgSel(sel), .Instruction(instr),
        .BranchAbs(babs), .BranchRelEn(brel), .ALU_flag(flag), .Target(target),
        .ProgCtr(pc), .Busy(busy), .Ack(ack), .CycleCt(cyc), .Timeout(to));

    prog_run_ctrl #(.PW(PW), .IW(IW), .CW(CW2), .NPROG(NPROG), .PROG_STRIDE(256),
                    .MAXCYC(MAX2)) dut2 (
        .Clk(clk), .Reset(rst), .Start(start), .ProgSel(sel), .Instruction(instr),
        .BranchAbs(babs), .BranchRelEn(brel), .ALU_flag(flag), .Target(target),
        .ProgCtr(pc2), .Busy(busy2), .Ack(ack2), .CycleCt(cyc2), .Timeout(to2));

    typedef struct {
        logic       rst, start;
        logic [1:0] sel;
        logic [8:0] instr;
        logic       babs, brel, flag;
        logic [9:0] target;
        logic [9:0] e_pc;
        logic       e_busy, e_ack;
        logic [15:0] e_cyc;
    } vec_t;

    vec_t vecs[20];
    int   checks = 0;
    int   passes = 0;

    // Reference model state.
    bit   m_run, m_ack;
    int   m_pc, m_cyc;

    function automatic vec_t v(input logic r, input logic s, input logic [1:0] ps,
                               input logic [8:0] ins, input logic ba, input logic br,
                               input logic fl, input logic [9:0] tg, input logic [9:0] epc,
                               input logic eb, input logic ea, input logic [15:0] ec);
        vec_t x;
        x.rst = r; x.start = s; x.sel = ps; x.instr = ins;
        x.babs = ba; x.brel = br; x.flag = fl; x.target = tg;
        x.e_pc = epc; x.e_busy = eb; x.e_ack = ea; x.e_cyc = ec;
        return x;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] ps,
                         input logic [8:0] ins, input logic ba, input logic br,
                         input logic fl, input logic [9:0] tg);
        rst = r; start = s; sel = ps; instr = ins;
        babs = ba; brel = br; flag = fl; target = tg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next-cycle behaviour from the rules, using integer arithmetic.
    task automatic model_step();
        int off;
        if (rst) begin
            m_run = 0; m_ack = 0; m_pc = 0; m_cyc = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_ack = 0; m_cyc = 0;
                m_pc = (int'(sel) * 256) % 1024;
            end
        end else if (instr == HALT) begin
            m_run = 0; m_ack = 1;
        end else begin
            if (m_cyc < 65535) m_cyc = m_cyc + 1;
            if (babs) m_pc = int'(target);
            else if (brel && flag) begin
                off  = (target >= 10'd512) ? int'(target) - 1024 : int'(target);
                m_pc = (m_pc + off + 1024) % 1024;
            end else m_pc = (m_pc + 1) % 1024;
        end
    endtask

    initial begin
        drive(1, 0, 0, NOP, 0, 0, 0, 0);

        //            rst st sel instr babs brel flg target   pc     busy ack cyc
        vecs[0]  = v(1, 0, 0, NOP,  0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
        vecs[1]  = v(0, 1, 2, NOP,  0, 0, 0, 10'h000, 10'h200, 1, 0, 0);
        vecs[2]  = v(0, 0, 0, NOP,  0, 0, 0, 10'h000, 10'h201, 1, 0, 1);
        vecs[3]  = v(0, 0, 0, NOP,  0, 0, 0, 10'h000, 10'h202, 1, 0, 2);
        vecs[4]  = v(0, 0, 0, NOP,  0, 0, 0, 10'h000, 10'h203, 1, 0, 3);
        vecs[5]  = v(0, 0, 0, HALT, 0, 0, 0, 10'h000, 10'h203, 0, 1, 3);
        vecs[6]  = v(0, 0, 0, NOP,  1, 0, 0, 10'h055, 10'h203, 0, 1, 3);
        vecs[7]  = v(0, 1, 1, NOP,  0, 0, 0, 10'h000, 10'h100, 1, 0, 0);
        vecs[8]  = v(0, 1, 3, NOP,  0, 0, 0, 10'h000, 10'h101, 1, 0, 1);
        vecs[9]  = v(0, 0, 0, NOP,  1, 0, 0, 10'h010, 10'h010, 1, 0, 2);
        vecs[10] = v(0, 0, 0, NOP,  1, 0, 0, 10'h3F0, 10'h3F0, 1, 0, 3);
        vecs[11] = v(0, 0, 0, NOP,  0, 1, 1, 10'h3FE, 10'h3EE, 1, 0, 4);
        vecs[12] = v(0, 0, 0, NOP,  0, 1, 0, 10'h3FE, 10'h3EF, 1, 0, 5);
        vecs[13] = v(0, 0, 0, NOP,  1, 0, 0, 10'h3FF, 10'h3FF, 1, 0, 6);
        vecs[14] = v(0, 0, 0, NOP,  0, 0, 0, 10'h000, 10'h000, 1, 0, 7);
        vecs[15] = v(0, 0, 0, NOP,  1, 1, 1, 10'h020, 10'h020, 1, 0, 8);
        vecs[16] = v(0, 0, 0, NOP,  0, 1, 1, 10'h005, 10'h025, 1, 0, 9);
        vecs[17] = v(1, 0, 0, NOP,  0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
        vecs[18] = v(0, 0, 0, NOP,  0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
        vecs[19] = v(1, 1, 3, NOP,  1, 0, 0, 10'h111, 10'h000, 0, 0, 0);

        tick();
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].sel, vecs[i].instr,
                  vecs[i].babs, vecs[i].brel, vecs[i].flag, vecs[i].target);
            tick();
            chk($sformatf("vec%0d_pc", i),   pc,   vecs[i].e_pc);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_ack", i),  ack,  vecs[i].e_ack);
            chk($sformatf("vec%0d_cyc", i),  cyc,  vecs[i].e_cyc);
            chk($sformatf("vec%0d_to", i),   to,   0);
        end

`ifdef PROG_RUN_CTRL_WATCHDOG_EN
        // Jump-to-self loop hits the limit of 8 cycles.
        drive(1, 0, 0, NOP, 0, 0, 0, 0);   tick();
        drive(0, 1, 0, NOP, 0, 0, 0, 0);   tick();
        drive(0, 0, 0, NOP, 1, 0, 0, 0);
        repeat (7) tick();
        chk("wd_busy_at7", busy2, 1);
        chk("wd_cyc_at7",  cyc2,  7);
        chk("wd_to_at7",   to2,   0);
        tick();
        chk("wd_ack",  ack2,  1);
        chk("wd_to",   to2,   1);
        chk("wd_cyc",  cyc2,  8);
        chk("wd_pc",   pc2,   0);
        chk("wd_busy", busy2, 0);
        drive(0, 0, 0, NOP, 0, 0, 0, 0);   tick();
        chk("wd_to_hold", to2, 1);
        drive(0, 1, 0, NOP, 1, 0, 0, 0);   tick();
        chk("wd_to_clr",  to2,   0);
        chk("wd_ack_clr", ack2,  0);
        chk("wd_rerun",   busy2, 1);
        drive(0, 0, 0, NOP, 1, 0, 0, 0);
        repeat (7) tick();
        drive(0, 0, 0, HALT, 1, 0, 0, 0);  tick();
        chk("wd_halt_ack", ack2, 1);
        chk("wd_halt_to",  to2,  0);
        chk("wd_halt_cyc", cyc2, 7);
`else
        // A 4-bit counter must stick at 15.
        drive(1, 0, 0, NOP, 0, 0, 0, 0);   tick();
        drive(0, 1, 0, NOP, 0, 0, 0, 0);   tick();
        drive(0, 0, 0, NOP, 0, 0, 0, 0);
        repeat (20) tick();
        chk("sat_cyc",  cyc2,  15);
        chk("sat_busy", busy2, 1);
        chk("sat_to",   to2,   0);
        drive(0, 0, 0, HALT, 0, 0, 0, 0);  tick();
        chk("sat_halt_ack", ack2, 1);
        chk("sat_halt_cyc", cyc2, 15);
`endif

        // Randomized traffic against the model.
        drive(1, 0, 0, NOP, 0, 0, 0, 0);
        model_step();
        tick();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom % 64) == 0, ($urandom % 6) == 0, 2'($urandom % 4),
                  (($urandom % 12) == 0) ? HALT : 9'($urandom % 511),
                  ($urandom % 8) == 0, ($urandom % 3) == 0, 1'($urandom % 2),
                  10'($urandom % 1024));
            model_step();
            tick();
            chk($sformatf("rnd%0d_pc", n),   pc,   m_pc);
            chk($sformatf("rnd%0d_busy", n), busy, m_run);
            chk($sformatf("rnd%0d_ack", n),  ack,  m_ack);
            chk($sformatf("rnd%0d_cyc", n),  cyc,  m_cyc);
            chk($sformatf("rnd%0d_to", n),   to,   0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
Parametrised program-execution controller. It succeeds the fixed 10-bit fetch/halt/cycle-count logic of the single-program core. It owns the program counter, the Start/Ack run handshake and the executed-cycle counter. It selects one of NPROG program slots at start, supports absolute jumps and signed relative branches, and detects the halt instruction. It sits between the instruction ROM and the control decoder in the processor top level.

Parameters:
PW, 10, program counter width in bits
IW, 9, instruction width; halt encoding is all ones
CW, 16, cycle counter width
NPROG, 4, number of program slots (power of 2, >=2)
PROG_STRIDE, 256, ROM address distance between slot start addresses
MAXCYC, 16'hFFF0, watchdog cycle limit (used only with WATCHDOG_EN)

Ports:
Clk  in  1  clock, posedge
Reset  in  1  synchronous, active-high reset
Start  in  1  start request, sampled at posedge
ProgSel  in  $clog2(NPROG)  program slot, sampled with accepted Start
Instruction  in  IW  current instruction from ROM, addressed by ProgCtr
BranchAbs  in  1  absolute jump enable (unconditional)
BranchRelEn  in  1  relative branch enable, taken only when ALU_flag=1
ALU_flag  in  1  ALU zero flag
Target  in  PW  jump address (abs) or two's-complement offset (rel)
ProgCtr  out  PW  program counter, registered
Busy  out  1  high in RUN
Ack  out  1  high in DONE
CycleCt  out  CW  executed-cycle count of current/last run
Timeout  out  1  run ended by watchdog

Behaviour:
- Reset (synchronous, Reset=1 at posedge): state IDLE, ProgCtr=0, CycleCt=0, Busy=0, Ack=0, Timeout=0. Reset has priority over every other input. Reset mid-run aborts with no Ack.
- FSM states are IDLE, RUN and DONE. Busy=(state==RUN) and Ack=(state==DONE), both decoded from the registered state.
- IDLE or DONE with Start=1: next state RUN. ProgCtr<=ProgSel*PROG_STRIDE, truncated to PW. CycleCt<=0 and Timeout<=0. Ack drops the cycle after Start.
- IDLE or DONE with Start=0: hold all registers.
- RUN with Start=1: Start is ignored. There is no restart mid-run.
- RUN with Instruction=={IW{1'b1}} (halt): next state DONE. ProgCtr holds at the halt address. CycleCt does not increment. Ack rises one cycle after the halt word is presented.
- RUN with a non-halt instruction: CycleCt<=CycleCt+1, saturating at all-ones. ProgCtr is updated with this priority:
  1. BranchAbs=1: ProgCtr<=Target.
  2. BranchRelEn=1 and ALU_flag=1: ProgCtr<=ProgCtr+Target, modulo 2^PW, with Target treated as signed.
  3. Otherwise: ProgCtr<=ProgCtr+1, wrapping from 2^PW-1 to 0.
- BranchRelEn=1 with ALU_flag=0 falls through to ProgCtr+1.
- Branch inputs are ignored outside RUN.
- Latency: one cycle from accepted Start to the first fetch address on ProgCtr.

Optional Feature:
Macro: PROG_RUN_CTRL_WATCHDOG_EN.
- Defined: in RUN, if the next CycleCt value would equal MAXCYC, next state is DONE and Timeout<=1. ProgCtr holds, and Ack rises as for a normal halt. Timeout stays high until the next accepted Start or Reset. If halt and the limit occur in the same cycle, halt wins and Timeout stays 0.
- Undefined: Timeout is tied to 0 and runs are unbounded, with CycleCt saturating.

Test Plan:
1. Reset, then Start=1 with ProgSel=2, then sequential non-halt instructions with halt at 0x203 -> ProgCtr goes 0x200, 0x201, 0x202, 0x203; Ack=1 one cycle later; CycleCt=3; Busy=0.
2. In RUN at PC=0x010, BranchAbs=1 with Target=0x3F0; at the next cycle BranchRelEn=1, ALU_flag=1, Target=10'h3FE (-2) -> ProgCtr goes 0x3F0 then 0x3EE. Repeating the relative branch with ALU_flag=0 gives 0x3EF.
3. PC=0x3FF with no branch -> ProgCtr wraps to 0x000. Both BranchAbs and BranchRelEn high -> the absolute target is taken.
4. DONE with Ack=1, then Start with ProgSel=1 -> Ack=0 next cycle, ProgCtr=0x100, CycleCt=0. A Start pulse during RUN -> no effect on ProgCtr or CycleCt.
5. Reset asserted mid-run at CycleCt=5 -> next cycle state IDLE, ProgCtr=0, CycleCt=0, and Ack never asserts.
6. With WATCHDOG_EN and MAXCYC=8, loop on BranchAbs to self with no halt -> DONE after CycleCt=8, Timeout=1, Ack=1. With halt arriving at the limit cycle, Timeout=0.
